// File: rtl/multi_channel_adc_averager_if.sv
// ============================================================================
// Module   : multi_channel_adc_averager_if
// Brief    : Sample-strobe / averaged-result bundle for the ADC averager.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface multi_channel_adc_averager_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 16,
    parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic                       clear;
    logic [NUM_CH-1:0]          ch_ready;
    logic [NUM_CH*DATA_W-1:0]   ch_data;
    logic [SEL_W-1:0]           ch_select;
    logic [DATA_W-1:0]          ave_data;
    logic                       ave_valid;
    logic [SEL_W-1:0]           ave_channel;
    logic [NUM_CH-1:0]          ch_primed;

    modport master (
        output clear, ch_ready, ch_data, ch_select,
        input  ave_data, ave_valid, ave_channel, ch_primed
    );

    modport slave (
        input  clear, ch_ready, ch_data, ch_select,
        output ave_data, ave_valid, ave_channel, ch_primed
    );
endinterface

`default_nettype wire

// File: rtl/multi_channel_adc_averager.sv
// ============================================================================
// Module   : multi_channel_adc_averager
// Brief    : N-channel concurrent block averager with one selected output.
//            ADC_AVG_EMA_EN selects an exponential moving average instead.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module multi_channel_adc_averager #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 16,
    parameter int AVG_POW = 8,
    parameter int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  wire logic                        clk,
    input  wire logic                        reset,
    multi_channel_adc_averager_if.slave      bus
);

    localparam int ACC_W = DATA_W + AVG_POW;

    logic [ACC_W-1:0]   acc      [NUM_CH];
    logic [ACC_W-1:0]   acc_nxt  [NUM_CH];
    logic [DATA_W-1:0]  res      [NUM_CH];
    logic [NUM_CH-1:0]  done;
    logic [NUM_CH-1:0]  primed;

    logic               sel_ok;
    logic               sel_done;
    logic [DATA_W-1:0]  sel_res;

    logic [DATA_W-1:0]  ave_data;
    logic               ave_valid;
    logic [SEL_W-1:0]   ave_channel;

`ifndef ADC_AVG_EMA_EN
    localparam logic [AVG_POW-1:0] CNT_MAX = {AVG_POW{1'b1}};
    logic [AVG_POW-1:0] cnt [NUM_CH];
`endif

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
`ifdef ADC_AVG_EMA_EN
            acc_nxt[k] = acc[k] - (acc[k] >> AVG_POW)
                       + {{AVG_POW{1'b0}}, bus.ch_data[k*DATA_W +: DATA_W]};
`else
            acc_nxt[k] = acc[k] + {{AVG_POW{1'b0}}, bus.ch_data[k*DATA_W +: DATA_W]};
`endif
        end
    end

    // Every channel accumulates in parallel; clear outranks a same-edge sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                acc[k] <= '0;
                res[k] <= '0;
`ifndef ADC_AVG_EMA_EN
                cnt[k] <= '0;
`endif
            end
            done   <= '0;
            primed <= '0;
        end else begin
            done <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                if (bus.clear) begin
                    acc[k] <= '0;
`ifdef ADC_AVG_EMA_EN
                    res[k] <= '0;
`else
                    cnt[k] <= '0;
`endif
                end else if (bus.ch_ready[k]) begin
`ifdef ADC_AVG_EMA_EN
                    acc[k]    <= acc_nxt[k];
                    res[k]    <= acc_nxt[k][ACC_W-1:AVG_POW];
                    done[k]   <= 1'b1;
                    primed[k] <= 1'b1;
`else
                    if (cnt[k] == CNT_MAX) begin
                        res[k]    <= acc_nxt[k][ACC_W-1:AVG_POW];
                        acc[k]    <= '0;
                        cnt[k]    <= '0;
                        done[k]   <= 1'b1;
                        primed[k] <= 1'b1;
                    end else begin
                        acc[k] <= acc_nxt[k];
                        cnt[k] <= cnt[k] + AVG_POW'(1);
                    end
`endif
                end
            end
        end
    end

    // Compare-based select avoids indexing past NUM_CH when SEL_W is wide.
    always_comb begin
        sel_ok   = 1'b0;
        sel_done = 1'b0;
        sel_res  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (bus.ch_select == SEL_W'(k)) begin
                sel_ok   = 1'b1;
                sel_done = done[k];
                sel_res  = primed[k] ? res[k] : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ave_data    <= '0;
            ave_valid   <= 1'b0;
            ave_channel <= '0;
        end else begin
            ave_channel <= bus.ch_select;
            ave_data    <= sel_ok ? sel_res : '0;
            ave_valid   <= sel_ok & sel_done & ~bus.clear;
        end
    end

    assign bus.ave_data    = ave_data;
    assign bus.ave_valid   = ave_valid;
    assign bus.ave_channel = ave_channel;
    assign bus.ch_primed   = primed;

endmodule

`default_nettype wire

// File: tb/tb_multi_channel_adc_averager.sv
// ============================================================================
// Module   : tb_multi_channel_adc_averager
// Brief    : Self-checking bench: vector table, corner sequences, random run.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multi_channel_adc_averager;

    localparam int NCH   = 4;
    localparam int DW    = 16;
    localparam int POW   = 2;
    localparam int SW    = 3;
    localparam int NAVG  = 4;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    multi_channel_adc_averager_if #(.NUM_CH(NCH), .DATA_W(DW), .SEL_W(SW)) bus ();

    multi_channel_adc_averager #(
        .NUM_CH(NCH), .DATA_W(DW), .AVG_POW(POW), .SEL_W(SW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: sample lists per channel, averaged by plain division.
    int unsigned     smp     [NCH][$];
    longint unsigned m_acc   [NCH];
    int unsigned     m_res   [NCH];
    bit              m_done  [NCH];
    bit [NCH-1:0]    m_primed;

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            smp[k].delete();
            m_acc[k]  = 0;
            m_res[k]  = 0;
            m_done[k] = 0;
        end
        m_primed = '0;
    endtask

    task automatic model_update(input logic [NCH-1:0] rdy, input logic [NCH*DW-1:0] data,
                                input logic clr);
        for (int k = 0; k < NCH; k++) begin
            int unsigned d;
            d = int'(data[k*DW +: DW]);
            m_done[k] = 0;
            if (clr) begin
                smp[k].delete();
                m_acc[k] = 0;
`ifdef ADC_AVG_EMA_EN
                m_res[k] = 0;
`endif
            end else if (rdy[k]) begin
`ifdef ADC_AVG_EMA_EN
                m_acc[k]    = m_acc[k] - m_acc[k] / NAVG + d;
                m_res[k]    = int'(m_acc[k] / NAVG);
                m_done[k]   = 1;
                m_primed[k] = 1'b1;
`else
                smp[k].push_back(d);
                if (smp[k].size() == NAVG) begin
                    longint unsigned s;
                    s = 0;
                    foreach (smp[k][i]) s += smp[k][i];
                    m_res[k]    = int'(s / NAVG);
                    m_done[k]   = 1;
                    m_primed[k] = 1'b1;
                    smp[k].delete();
                end
`endif
            end
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock with the given inputs; outputs checked against the model.
    task automatic step(input logic [NCH-1:0] rdy, input logic [NCH*DW-1:0] data,
                        input logic [SW-1:0] sel, input logic clr);
        int          s;
        int unsigned e_data;
        bit          e_valid;
        bus.ch_ready  = rdy;
        bus.ch_data   = data;
        bus.ch_select = sel;
        bus.clear     = clr;
        @(posedge clk);
        #1;
        s       = int'(sel);
        e_data  = 0;
        e_valid = 0;
        if (s < NCH) begin
            e_data  = m_res[s];
            e_valid = m_done[s] && !clr;
        end
        model_update(rdy, data, clr);
        chk("model ave_data",    64'(bus.ave_data),    64'(e_data));
        chk("model ave_valid",   64'(bus.ave_valid),   64'(e_valid));
        chk("model ave_channel", 64'(bus.ave_channel), 64'(sel));
        chk("model ch_primed",   64'(bus.ch_primed),   64'(m_primed));
    endtask

    typedef struct {
        logic [NCH-1:0] rdy;
        logic [DW-1:0]  d0;
        logic [DW-1:0]  e_data;
        logic           e_valid;
        logic [NCH-1:0] e_primed;
    } vec_t;

    function automatic vec_t mk(input logic [NCH-1:0] rdy, input logic [DW-1:0] d0,
                                input logic [DW-1:0] ed, input logic ev, input logic [NCH-1:0] ep);
        vec_t v;
        v.rdy = rdy; v.d0 = d0; v.e_data = ed; v.e_valid = ev; v.e_primed = ep;
        return v;
    endfunction

    initial begin
        vec_t tbl [17];
        int   pulses;

        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        bus.clear     = 1'b0;
        bus.ch_ready  = '0;
        bus.ch_data   = '0;
        bus.ch_select = '0;
        model_reset();

        // Reset held: outputs pinned at zero regardless of input activity.
        for (int i = 0; i < 5; i++) begin
            bus.ch_ready  = 4'($urandom);
            bus.ch_data   = {$urandom, $urandom};
            bus.ch_select = SW'($urandom);
            @(posedge clk);
            #1;
            chk("rst ave_data",    64'(bus.ave_data),    64'h0);
            chk("rst ave_valid",   64'(bus.ave_valid),   64'h0);
            chk("rst ave_channel", 64'(bus.ave_channel), 64'h0);
            chk("rst ch_primed",   64'(bus.ch_primed),   64'h0);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step('0, '0, 3'd0, 1'b0);
            chk("post-rst ave_data", 64'(bus.ave_data), 64'h0);
        end

`ifndef ADC_AVG_EMA_EN
        tbl[0]  = mk(4'b0001, 16'h1000, 16'h0000, 1'b0, 4'b0000);
        tbl[1]  = mk(4'b0001, 16'h2000, 16'h0000, 1'b0, 4'b0000);
        tbl[2]  = mk(4'b0001, 16'h3000, 16'h0000, 1'b0, 4'b0000);
        tbl[3]  = mk(4'b0001, 16'h4000, 16'h0000, 1'b0, 4'b0001);
        tbl[4]  = mk(4'b0000, 16'h0000, 16'h2800, 1'b1, 4'b0001);
        tbl[5]  = mk(4'b0000, 16'h0000, 16'h2800, 1'b0, 4'b0001);
        tbl[6]  = mk(4'b0001, 16'hFFFF, 16'h2800, 1'b0, 4'b0001);
        tbl[7]  = mk(4'b0001, 16'hFFFF, 16'h2800, 1'b0, 4'b0001);
        tbl[8]  = mk(4'b0001, 16'hFFFF, 16'h2800, 1'b0, 4'b0001);
        tbl[9]  = mk(4'b0001, 16'hFFFF, 16'h2800, 1'b0, 4'b0001);
        tbl[10] = mk(4'b0000, 16'h0000, 16'hFFFF, 1'b1, 4'b0001);
        tbl[11] = mk(4'b0000, 16'h0000, 16'hFFFF, 1'b0, 4'b0001);
        tbl[12] = mk(4'b0001, 16'h0001, 16'hFFFF, 1'b0, 4'b0001);
        tbl[13] = mk(4'b0001, 16'h0000, 16'hFFFF, 1'b0, 4'b0001);
        tbl[14] = mk(4'b0001, 16'h0000, 16'hFFFF, 1'b0, 4'b0001);
        tbl[15] = mk(4'b0001, 16'h0000, 16'hFFFF, 1'b0, 4'b0001);
        tbl[16] = mk(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0001);

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].rdy, {48'h0, tbl[i].d0}, 3'd0, 1'b0);
            chk($sformatf("vec%0d ave_data", i),  64'(bus.ave_data),  64'(tbl[i].e_data));
            chk($sformatf("vec%0d ave_valid", i), 64'(bus.ave_valid), 64'(tbl[i].e_valid));
            chk($sformatf("vec%0d ch_primed", i), 64'(bus.ch_primed), 64'(tbl[i].e_primed));
        end

        // ch1 and ch2 strobed together, observed via select 2 then select 1.
        for (int i = 0; i < 4; i++)
            step(4'b0110, {16'h0000, 16'h0300, 16'h0100, 16'h0000}, 3'd2, 1'b0);
        step('0, '0, 3'd2, 1'b0);
        chk("dual ch2 ave_data",  64'(bus.ave_data),  64'h0300);
        chk("dual ch2 ave_valid", 64'(bus.ave_valid), 64'h1);
        step('0, '0, 3'd1, 1'b0);
        chk("switch ave_data",    64'(bus.ave_data),    64'h0100);
        chk("switch ave_channel", 64'(bus.ave_channel), 64'h1);
        chk("switch ave_valid",   64'(bus.ave_valid),   64'h0);
        chk("dual ch_primed",     64'(bus.ch_primed),   64'h7);

        // Asynchronous reset mid-cycle clears outputs without waiting for an edge.
        #3;
        reset = 1'b0;
        #1;
        chk("async ave_data",    64'(bus.ave_data),    64'h0);
        chk("async ave_channel", 64'(bus.ave_channel), 64'h0);
        chk("async ch_primed",   64'(bus.ch_primed),   64'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Clear on the third sample restarts the block.
        pulses = 0;
        step(4'b0001, 64'h0111, 3'd0, 1'b0); pulses += int'(bus.ave_valid);
        step(4'b0001, 64'h0222, 3'd0, 1'b0); pulses += int'(bus.ave_valid);
        step(4'b0001, 64'h0333, 3'd0, 1'b1); pulses += int'(bus.ave_valid);
        for (int i = 0; i < 4; i++) begin
            step(4'b0001, 64'h0800, 3'd0, 1'b0);
            pulses += int'(bus.ave_valid);
        end
        step('0, '0, 3'd0, 1'b0); pulses += int'(bus.ave_valid);
        step('0, '0, 3'd0, 1'b0); pulses += int'(bus.ave_valid);
        chk("clear pulse count", 64'(pulses), 64'h1);
        chk("clear ave_data",    64'(bus.ave_data), 64'h0800);

        // Out-of-range select hides a completing channel.
        for (int i = 0; i < 4; i++)
            step(4'b0001, 64'h0100, 3'd5, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step('0, '0, 3'd5, 1'b0);
            chk("oor ave_data",  64'(bus.ave_data),  64'h0);
            chk("oor ave_valid", 64'(bus.ave_valid), 64'h0);
        end
        chk("oor ave_channel", 64'(bus.ave_channel), 64'h5);
`else
        step(4'b0001, 64'h0400, 3'd0, 1'b0);
        step(4'b0001, 64'h0400, 3'd0, 1'b0);
        chk("ema first ave_data",   64'(bus.ave_data),  64'h0100);
        chk("ema first ave_valid",  64'(bus.ave_valid), 64'h1);
        step(4'b0001, 64'h0400, 3'd0, 1'b0);
        chk("ema second ave_data",  64'(bus.ave_data),  64'h01C0);
        chk("ema second ave_valid", 64'(bus.ave_valid), 64'h1);
`endif

        // Randomised traffic on all channels, including wide selects and clears.
        for (int i = 0; i < 600; i++) begin
            step(4'($urandom), {$urandom, $urandom}, SW'($urandom_range(0, 5)),
                 ($urandom_range(0, 31) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
